// File: rtl/sound_sequencer_pkg.sv
// Shared types and constants for the Pong sound sequencer.
// State encoding and event index / one-hot grant values.
package sound_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NOTE1 = 2'd1,
        S_GAP   = 2'd2,
        S_NOTE2 = 2'd3
    } state_e;

    localparam int EV_PADDLE = 0;
    localparam int EV_WALL   = 1;
    localparam int EV_SCORE  = 2;

    localparam logic [2:0] G_NONE   = 3'b000;
    localparam logic [2:0] G_PADDLE = 3'b001;
    localparam logic [2:0] G_WALL   = 3'b010;
    localparam logic [2:0] G_SCORE  = 3'b100;

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave tone generator: 50% duty, restartable phase.
// Output goes high on the first enabled edge after a restart.
module tone_gen (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        restart,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        wave
);

    logic [31:0] cnt_q, cnt_d;
    logic        wave_q, wave_d;

    // phase counter wraps at period-1; high for the first half
    always_comb begin
        cnt_d  = '0;
        wave_d = 1'b0;
        if (enable && !restart) begin
            wave_d = (cnt_q < (period >> 1));
            cnt_d  = (cnt_q >= period - 32'd1) ? '0 : cnt_q + 32'd1;
        end
    end

    // phase and output registers
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/sound_sequencer.sv
// Pong sound sequencer: arbitrates paddle/wall/score events
// onto one piezo pin, with a two-note jingle for the score.
module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned PADDLE_PERIOD = 100000,
    parameter int unsigned WALL_PERIOD   = 200000,
    parameter int unsigned SCORE_PERIOD1 = 50000,
    parameter int unsigned SCORE_PERIOD2 = 25000,
    parameter int unsigned PADDLE_MS     = 30,
    parameter int unsigned WALL_MS       = 30,
    parameter int unsigned SCORE_MS      = 120,
    parameter int unsigned GAP_MS        = 40
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       mute,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       busy,
    output logic       buzzer_out
);

    localparam logic [31:0] TD  = 32'(TICK_DIV);
    localparam logic [31:0] PP  = 32'(PADDLE_PERIOD);
    localparam logic [31:0] WP  = 32'(WALL_PERIOD);
    localparam logic [31:0] SP1 = 32'(SCORE_PERIOD1);
    localparam logic [31:0] SP2 = 32'(SCORE_PERIOD2);
    localparam logic [31:0] PMS = 32'(PADDLE_MS);
    localparam logic [31:0] WMS = 32'(WALL_MS);
    localparam logic [31:0] SMS = 32'(SCORE_MS);
    localparam logic [31:0] GMS = 32'(GAP_MS);

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  pend_q, pend_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] ms_q, ms_d;
    logic        busy_q, busy_d;

    logic [2:0]  sel, win;
    logic [31:0] len, period;
    logic        tick_end, take, start, enter, finish;
    logic        tone_rst, tone_en;

    function automatic logic [2:0] pick(input logic [2:0] s);
        if (s[EV_SCORE])     return G_SCORE;
        else if (s[EV_WALL]) return G_WALL;
        else if (s[EV_PADDLE]) return G_PADDLE;
        else                 return G_NONE;
    endfunction

    // arbitration, FSM next state and note timing
    always_comb begin
        sel      = pend_q | req;
        win      = pick(sel);
        len      = 32'd0;
        unique case (state_q)
            S_NOTE1: len = grant_q[EV_SCORE] ? SMS :
                           grant_q[EV_WALL]  ? WMS : PMS;
            S_GAP:   len = GMS;
            S_NOTE2: len = SMS;
            default: len = 32'd0;
        endcase
        tick_end = (pre_q == TD - 32'd1) && (ms_q == len - 32'd1);
        finish   = tick_end && ((state_q == S_NOTE2) ||
                   (state_q == S_NOTE1 && !grant_q[EV_SCORE]));
        state_d  = state_q;
        grant_d  = grant_q;
        take     = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|sel) begin
                    state_d = S_NOTE1;
                    grant_d = win;
                    take    = 1'b1;
                end
            end
            S_NOTE1: begin
                if (req[EV_SCORE] && !grant_q[EV_SCORE]) begin
                    grant_d = G_SCORE;
                    take    = 1'b1;
                end else if (tick_end && grant_q[EV_SCORE]) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick_end) begin
                    state_d = S_NOTE2;
                    start   = 1'b1;
                end
            end
            default: ;
        endcase
        if (finish) begin
            if (|sel) begin
                state_d = S_NOTE1;
                grant_d = win;
                take    = 1'b1;
            end else begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
        end
        start  = start | take;
        enter  = start | (state_d != state_q);
        pend_d = take ? (sel & ~grant_d) : sel;
        busy_d = (state_d != S_IDLE);
        if (enter || state_d == S_IDLE) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (pre_q == TD - 32'd1) begin
            pre_d = '0;
            ms_d  = ms_q + 32'd1;
        end else begin
            pre_d = pre_q + 32'd1;
            ms_d  = ms_q;
        end
        tone_en = (state_d == S_NOTE1) || (state_d == S_NOTE2);
        if (state_d == S_NOTE2)       period = SP2;
        else if (grant_d[EV_SCORE])   period = SP1;
        else if (grant_d[EV_WALL])    period = WP;
        else                          period = PP;
    end

    // state, arbitration and tick registers; mute acts as a clear
    always_ff @(posedge clk_100MHz) begin
        if (rst || mute) begin
            state_q <= S_IDLE;
            grant_q <= G_NONE;
            pend_q  <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pend_q  <= pend_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            busy_q  <= busy_d;
        end
    end

    assign tone_rst = rst | mute;

    tone_gen u_tone (
        .clk_100MHz (clk_100MHz),
        .rst        (tone_rst),
        .restart    (start),
        .enable     (tone_en),
        .period     (period),
        .wave       (buzzer_out)
    );

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: vector table, directed
// corner sequences and random traffic against a cycle-count model.
module tb_sound_sequencer;

    localparam int TD  = 10;
    localparam int PP  = 4;
    localparam int WP  = 6;
    localparam int SP1 = 4;
    localparam int SP2 = 2;
    localparam int PMS = 3;
    localparam int WMS = 3;
    localparam int SMS = 2;
    localparam int GMS = 1;

    logic       clk_100MHz = 1'b0;
    logic       rst = 1'b1;
    logic       mute = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic       busy;
    logic       buzzer_out;

    int errs = 0;
    int checks = 0;

    // model: active flag, event, phase (0 note1, 1 gap, 2 note2),
    // cycles elapsed in phase since its entry edge, pending events
    bit       m_act = 1'b0;
    int       m_ev = 0;
    int       m_ph = 0;
    int       m_el = 0;
    bit [2:0] m_pend = 3'b000;

    sound_sequencer #(
        .TICK_DIV      (TD),
        .PADDLE_PERIOD (PP),
        .WALL_PERIOD   (WP),
        .SCORE_PERIOD1 (SP1),
        .SCORE_PERIOD2 (SP2),
        .PADDLE_MS     (PMS),
        .WALL_MS       (WMS),
        .SCORE_MS      (SMS),
        .GAP_MS        (GMS)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .mute       (mute),
        .req        (req),
        .grant      (grant),
        .busy       (busy),
        .buzzer_out (buzzer_out)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic int phase_cycles(int ev, int ph);
        if (ph == 1) return GMS * TD;
        if (ph == 2) return SMS * TD;
        if (ev == 2) return SMS * TD;
        if (ev == 1) return WMS * TD;
        return PMS * TD;
    endfunction

    function automatic int phase_period(int ev, int ph);
        if (ph == 2) return SP2;
        if (ev == 2) return SP1;
        if (ev == 1) return WP;
        return PP;
    endfunction

    function automatic int winner(bit [2:0] s);
        if (s[2]) return 2;
        if (s[1]) return 1;
        return 0;
    endfunction

    task automatic m_start(int ev);
        m_act = 1'b1;
        m_ev = ev;
        m_ph = 0;
        m_el = 0;
        m_pend[ev] = 1'b0;
    endtask

    task automatic m_step(bit r, bit m, bit [2:0] q);
        if (r || m) begin
            m_act = 1'b0;
            m_ev = 0;
            m_ph = 0;
            m_el = 0;
            m_pend = 3'b000;
        end else begin
            m_pend = m_pend | q;
            if (!m_act) begin
                if (m_pend != 3'b000) m_start(winner(m_pend));
            end else if (m_ph == 0 && m_ev != 2 && q[2]) begin
                m_start(2);
            end else if (m_el + 1 == phase_cycles(m_ev, m_ph)) begin
                if (m_ph == 0 && m_ev == 2) begin
                    m_ph = 1;
                    m_el = 0;
                end else if (m_ph == 1) begin
                    m_ph = 2;
                    m_el = 0;
                end else if (m_pend != 3'b000) begin
                    m_start(winner(m_pend));
                end else begin
                    m_act = 1'b0;
                end
            end else begin
                m_el = m_el + 1;
            end
        end
    endtask

    function automatic logic [4:0] m_out();
        logic [2:0] g;
        logic       z;
        int         p;
        g = 3'b000;
        z = 1'b0;
        if (m_act) begin
            g[m_ev] = 1'b1;
            p = phase_period(m_ev, m_ph);
            if (m_ph != 1 && m_el >= 1)
                z = (((m_el - 1) % p) < (p / 2));
        end
        return {g, m_act, z};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(bit r, bit m, bit [2:0] q, bit cmp);
        rst = r;
        mute = m;
        req = q;
        @(posedge clk_100MHz);
        m_step(r, m, q);
        #1;
        if (cmp)
            chk($sformatf("model@%0t", $time),
                {27'd0, grant, busy, buzzer_out}, {27'd0, m_out()});
    endtask

    task automatic run(bit [2:0] q, int n, bit [2:0] mask, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, (i == 0) ? q : 3'b000, 1'b1);
            if ((grant & mask) != 3'b000) hits++;
        end
    endtask

    typedef struct {
        bit       r;
        bit       m;
        bit [2:0] q;
        bit [2:0] g;
        bit       b;
        bit       z;
    } vec_t;

    vec_t tbl[13];
    int   h;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 3'b110, 3'b100, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].r, tbl[i].m, tbl[i].q, 1'b0);
            chk($sformatf("vec%0d", i),
                {27'd0, grant, busy, buzzer_out},
                {27'd0, tbl[i].g, tbl[i].b, tbl[i].z});
        end

        cyc(1'b1, 1'b0, 3'b000, 1'b1);
        run(3'b001, 40, 3'b111, h);
        chk("paddle_len", h, 30);

        run(3'b111, 125, 3'b001, h);
        chk("jingle_then_paddle", h, 30);
        chk("jingle_idle", {31'd0, busy}, 0);

        run(3'b001, 10, 3'b001, h);
        cyc(1'b0, 1'b0, 3'b100, 1'b1);
        chk("preempt_grant", {29'd0, grant}, 32'd4);
        chk("preempt_restart", {31'd0, buzzer_out}, 0);
        run(3'b000, 80, 3'b001, h);
        chk("preempt_no_replay", h, 0);

        run(3'b010, 5, 3'b010, h);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 3'b001, 1'b1);
            cyc(1'b0, 1'b0, 3'b000, 1'b1);
        end
        run(3'b000, 80, 3'b001, h);
        chk("coalesce_paddle", h, 30);

        run(3'b100, 24, 3'b111, h);
        chk("in_gap", {29'd0, grant}, 32'd4);
        cyc(1'b0, 1'b1, 3'b010, 1'b1);
        chk("mute_clear", {27'd0, grant, busy, buzzer_out}, 0);
        run(3'b000, 30, 3'b111, h);
        chk("mute_silent", h, 0);

        run(3'b100, 3, 3'b111, h);
        run(3'b001, 33, 3'b111, h);
        cyc(1'b1, 1'b0, 3'b000, 1'b1);
        chk("rst_note2", {27'd0, grant, busy, buzzer_out}, 0);
        run(3'b000, 60, 3'b111, h);
        chk("rst_pending_lost", h, 0);

        for (int i = 0; i < 4000; i++) begin
            bit       r;
            bit       m;
            bit [2:0] q;
            r = ($urandom_range(0, 999) == 0);
            m = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 3; b++)
                q[b] = ($urandom_range(0, 59) == 0);
            cyc(r, m, q, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
